// File: rtl/uu_acmac_mem_tx_dp.sv
// Dual-port TX buffer RAM: port A read/write with byte enables, port B read-only for the TX engine.
// Memory is zero-swept after every reset before any port access is honoured.
module uu_acmac_mem_tx_dp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 208,
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_en,
    input  logic                a_wen,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    input  logic                b_en,
    input  logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rvalid,
    output logic                init_done,
    output logic                err_oor,
    input  logic                err_clr
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_READY} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              err_q, err_d;

    logic              ready;
    logic              a_inr, b_inr;
    logic              a_ok, b_ok, a_oor, b_oor, a_wr;
    logic [IDX_W-1:0]  a_idx, b_idx, sw_idx;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] a_rd1_q, b_rd1_q;
    logic              a_vl1_q, b_vl1_q;

    assign ready  = (state_q == S_READY);
    assign a_inr  = (a_addr < DEPTH_A);
    assign b_inr  = (b_addr < DEPTH_A);
    assign a_ok   = ready && a_en && a_inr;
    assign b_ok   = ready && b_en && b_inr;
    assign a_oor  = ready && a_en && !a_inr;
    assign b_oor  = ready && b_en && !b_inr;
    assign a_wr   = a_ok && a_wen;
    assign a_idx  = a_addr[IDX_W-1:0];
    assign b_idx  = b_addr[IDX_W-1:0];
    assign sw_idx = sweep_q[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            S_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_A) begin
                    state_d = S_READY;
                    sweep_d = '0;
                end
            end
            default: ;
        endcase
    end

    // A new out-of-range access outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (a_oor || b_oor)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            sweep_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; the sweep clears it, and port writes are locked out until then.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem_q[sw_idx] <= '0;
        end else if (a_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i])
                    mem_q[a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
        end
    end

    // Reads sample the array before this edge's write lands, giving read-before-write on both ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rd1_q <= '0;
            b_rd1_q <= '0;
            a_vl1_q <= 1'b0;
            b_vl1_q <= 1'b0;
        end else begin
            a_rd1_q <= a_ok ? mem_q[a_idx] : '0;
            b_rd1_q <= b_ok ? mem_q[b_idx] : '0;
            a_vl1_q <= ready && a_en;
            b_vl1_q <= ready && b_en;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] a_rd2_q, b_rd2_q;
            logic              a_vl2_q, b_vl2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rd2_q <= '0;
                    b_rd2_q <= '0;
                    a_vl2_q <= 1'b0;
                    b_vl2_q <= 1'b0;
                end else begin
                    a_rd2_q <= a_rd1_q;
                    b_rd2_q <= b_rd1_q;
                    a_vl2_q <= a_vl1_q;
                    b_vl2_q <= b_vl1_q;
                end
            end

            assign a_rdata  = a_rd2_q;
            assign b_rdata  = b_rd2_q;
            assign a_rvalid = a_vl2_q;
            assign b_rvalid = b_vl2_q;
        end else begin : g_lat1
            assign a_rdata  = a_rd1_q;
            assign b_rdata  = b_rd1_q;
            assign a_rvalid = a_vl1_q;
            assign b_rvalid = b_vl1_q;
        end
    endgenerate

    assign init_done = ready;
    assign err_oor   = err_q;

endmodule

// File: tb/tb_uu_acmac_mem_tx_dp.sv
// Directed bench: one RD_LAT=1 instance for functional checks, one RD_LAT=2 instance for pipelining.
module tb_uu_acmac_mem_tx_dp;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_en, a_wen, b_en, err_clr;
    logic [3:0]  a_be;
    logic [13:0] a_addr, b_addr;
    logic [31:0] a_wdata, a_rdata, b_rdata;
    logic        a_rvalid, b_rvalid, init_done, err_oor;

    logic        d2_a_en, d2_a_wen, d2_b_en, d2_err_clr;
    logic [3:0]  d2_a_be;
    logic [13:0] d2_a_addr, d2_b_addr;
    logic [31:0] d2_a_wdata, d2_a_rdata, d2_b_rdata;
    logic        d2_a_rvalid, d2_b_rvalid, d2_init_done, d2_err_oor;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uu_acmac_mem_tx_dp #(.DATA_W(32), .DEPTH(208), .ADDR_W(14), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .init_done(init_done), .err_oor(err_oor), .err_clr(err_clr)
    );

    uu_acmac_mem_tx_dp #(.DATA_W(32), .DEPTH(208), .ADDR_W(14), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .a_en(d2_a_en), .a_wen(d2_a_wen), .a_be(d2_a_be), .a_addr(d2_a_addr), .a_wdata(d2_a_wdata),
        .a_rdata(d2_a_rdata), .a_rvalid(d2_a_rvalid),
        .b_en(d2_b_en), .b_addr(d2_b_addr), .b_rdata(d2_b_rdata), .b_rvalid(d2_b_rvalid),
        .init_done(d2_init_done), .err_oor(d2_err_oor), .err_clr(d2_err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_en = 0; a_wen = 0; a_be = 0; a_addr = 0; a_wdata = 0; b_en = 0; b_addr = 0; err_clr = 0;
        d2_a_en = 0; d2_a_wen = 0; d2_a_be = 0; d2_a_addr = 0; d2_a_wdata = 0;
        d2_b_en = 0; d2_b_addr = 0; d2_err_clr = 0;

        repeat (3) cyc();
        chk("rst_a_rdata",   a_rdata,   32'h0);
        chk("rst_b_rdata",   b_rdata,   32'h0);
        chk("rst_a_rvalid",  a_rvalid,  32'h0);
        chk("rst_b_rvalid",  b_rvalid,  32'h0);
        chk("rst_init_done", init_done, 32'h0);
        chk("rst_err_oor",   err_oor,   32'h0);
        chk("rst_d2_b_rvalid", d2_b_rvalid, 32'h0);

        // Release; hammer both ports during INIT, all of which must be ignored
        rst_n = 1'b1;
        a_en = 1; a_wen = 1; a_be = 4'hF; a_wdata = 32'hFFFF_FFFF; a_addr = 14'd3;
        b_en = 1; b_addr = 14'd300;
        for (int i = 1; i <= 208; i++) begin
            cyc();
            if (i == 100) a_addr = 14'd300;
            if (i == 50 || i == 150) begin
                chk("init_a_rvalid", a_rvalid, 32'h0);
                chk("init_b_rvalid", b_rvalid, 32'h0);
                chk("init_err_oor",  err_oor,  32'h0);
            end
            if (i == 207) chk("init_done_207", init_done, 32'h0);
            if (i == 208) begin
                chk("init_done_208",    init_done,    32'h1);
                chk("d2_init_done_208", d2_init_done, 32'h1);
                chk("init_err_end",     err_oor,      32'h0);
                a_en = 0; a_wen = 0; b_en = 0;
            end
        end

        // Boundary address and an address written only during INIT
        a_en = 1; a_wen = 0; a_addr = 14'd207;
        cyc();
        chk("rd207_data",  a_rdata,  32'h0);
        chk("rd207_valid", a_rvalid, 32'h1);
        a_addr = 14'd3;
        cyc();
        chk("init_wr_ignored", a_rdata, 32'h0);

        // Byte-enable merge with read-before-write
        a_wen = 1; a_be = 4'hF; a_addr = 14'd5; a_wdata = 32'hAABB_CCDD;
        cyc();
        chk("wr5_prewrite", a_rdata, 32'h0);
        a_be = 4'b0101; a_wdata = 32'h1122_3344;
        cyc();
        chk("wr5_be_prewrite", a_rdata, 32'hAABB_CCDD);
        a_wen = 0;
        cyc();
        chk("wr5_merged", a_rdata, 32'hAA22_CC44);
        a_wen = 1; a_be = 4'h0; a_wdata = 32'h0;
        cyc();
        chk("be0_read", a_rdata, 32'hAA22_CC44);
        a_wen = 0;
        cyc();
        chk("be0_kept", a_rdata, 32'hAA22_CC44);

        // Same-cycle A write / B read collision
        a_wen = 1; a_be = 4'hF; a_addr = 14'd9; a_wdata = 32'hFFFF_FFFF;
        b_en = 1; b_addr = 14'd9;
        cyc();
        chk("coll_b_old",   b_rdata,  32'h0);
        chk("coll_b_valid", b_rvalid, 32'h1);
        a_en = 0; a_wen = 0;
        cyc();
        chk("coll_b_new",   b_rdata,  32'hFFFF_FFFF);
        chk("a_dis_valid",  a_rvalid, 32'h0);
        chk("a_dis_data",   a_rdata,  32'h0);
        b_en = 0;
        cyc();
        chk("b_dis_valid", b_rvalid, 32'h0);
        chk("b_dis_data",  b_rdata,  32'h0);

        // Out-of-range write, then clear racing a new out-of-range read
        chk("err_pre", err_oor, 32'h0);
        a_en = 1; a_wen = 1; a_be = 4'hF; a_addr = 14'd300; a_wdata = 32'hDEAD_BEEF;
        cyc();
        chk("oor_a_data",  a_rdata,  32'h0);
        chk("oor_a_valid", a_rvalid, 32'h1);
        chk("oor_err_set", err_oor,  32'h1);
        a_en = 0; a_wen = 0;
        err_clr = 1; b_en = 1; b_addr = 14'd250;
        cyc();
        chk("clr_race_err",   err_oor,  32'h1);
        chk("clr_race_valid", b_rvalid, 32'h1);
        chk("clr_race_data",  b_rdata,  32'h0);
        b_en = 0;
        cyc();
        chk("clr_err", err_oor, 32'h0);
        err_clr = 0;
        a_en = 1; a_addr = 14'd44;
        cyc();
        chk("oor_alias_untouched", a_rdata, 32'h0);
        a_addr = 14'd5;
        cyc();
        chk("oor_addr5_untouched", a_rdata, 32'hAA22_CC44);
        a_en = 0;

        // RD_LAT=2: preload 0..3 with 1..4, then both ports streaming every cycle
        for (int j = 0; j < 4; j++) begin
            d2_a_en = 1; d2_a_wen = 1; d2_a_be = 4'hF; d2_a_addr = 14'(j); d2_a_wdata = 32'(j + 1);
            cyc();
        end
        d2_a_en = 0; d2_a_wen = 0;
        cyc();
        cyc();
        for (int j = 0; j < 6; j++) begin
            d2_b_en = (j < 4); d2_b_addr = 14'(j);
            d2_a_en = (j < 4); d2_a_addr = 14'(3 - j);
            cyc();
            chk("lat2_b_valid", d2_b_rvalid, (j >= 1 && j <= 4) ? 32'h1 : 32'h0);
            chk("lat2_b_data",  d2_b_rdata,  (j >= 1 && j <= 4) ? 32'(j) : 32'h0);
            chk("lat2_a_data",  d2_a_rdata,  (j >= 1 && j <= 4) ? 32'(5 - j) : 32'h0);
        end
        d2_a_en = 0; d2_b_en = 0;

        // Asynchronous reset mid-READY with a read in flight and the error flag set
        a_en = 1; a_wen = 0; a_addr = 14'd5; b_en = 1; b_addr = 14'd300;
        cyc();
        chk("pre_rst_valid", a_rvalid, 32'h1);
        chk("pre_rst_err",   err_oor,  32'h1);
        a_en = 0; b_en = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a_rdata",   a_rdata,   32'h0);
        chk("arst_a_rvalid",  a_rvalid,  32'h0);
        chk("arst_b_rvalid",  b_rvalid,  32'h0);
        chk("arst_err_oor",   err_oor,   32'h0);
        chk("arst_init_done", init_done, 32'h0);

        // Reset again at sweep count 100; full sweep must restart on release
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (100) cyc();
        chk("mid_init_done", init_done, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_init_done", init_done, 32'h0);
        chk("mid_rst_a_rvalid",  a_rvalid,  32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 1; i <= 208; i++) begin
            cyc();
            if (i == 207) chk("resweep_207", init_done, 32'h0);
            if (i == 208) chk("resweep_208", init_done, 32'h1);
        end
        a_en = 1; a_addr = 14'd5;
        cyc();
        chk("resweep_addr5", a_rdata, 32'h0);
        a_addr = 14'd9;
        cyc();
        chk("resweep_addr9", a_rdata, 32'h0);
        a_en = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uu_acmac_mem_tx_dp.md
UU_ACMAC_MEM_TX_DP -- requirements
Module: uu_acmac_mem_tx_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 208, number of words.
REQ-003 SHALL have parameter ADDR_W, default 14, address width.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles (legal values 1 or 2).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port a_en, input, 1, port A access enable.
REQ-008 SHALL have port a_wen, input, 1, port A write when 1, read-only when 0.
REQ-009 SHALL have port a_be, input, DATA_W/8, port A byte write enables.
REQ-010 SHALL have port a_addr, input, ADDR_W, port A word address.
REQ-011 SHALL have port a_wdata, input, DATA_W, port A write data.
REQ-012 SHALL have port a_rdata, output, DATA_W, port A read data.
REQ-013 SHALL have port a_rvalid, output, 1, a_rdata valid strobe.
REQ-014 SHALL have port b_en, input, 1, port B (TX engine) read enable.
REQ-015 SHALL have port b_addr, input, ADDR_W, port B word address.
REQ-016 SHALL have port b_rdata, output, DATA_W, port B read data.
REQ-017 SHALL have port b_rvalid, output, 1, b_rdata valid strobe.
REQ-018 SHALL have port init_done, output, 1, high once memory clear completes.
REQ-019 SHALL have port err_oor, output, 1, sticky out-of-range address flag.
REQ-020 SHALL have port err_clr, input, 1, clears err_oor.

Function
REQ-021 SHALL implement states INIT and READY; INIT entered on reset, READY entered after the clear sweep.
REQ-022 In INIT, SHALL write zero to addresses 0..DEPTH-1, one per cycle, ascending; transition to READY on cycle after writing DEPTH-1 (DEPTH cycles total).
REQ-023 init_done SHALL be 0 in INIT and 1 in READY.
REQ-024 In INIT, SHALL ignore a_en/b_en: no writes from ports, a_rvalid=b_rvalid=0, err_oor not set.
REQ-025 In READY, a_en=1 with a_addr<DEPTH SHALL return the pre-write word on a_rdata after RD_LAT cycles, with a_rvalid=1 for one cycle.
REQ-026 In READY, a_en=1, a_wen=1 SHALL update only bytes whose a_be bit is 1; a_be=0 performs read only.
REQ-027 b_en=1 with b_addr<DEPTH SHALL return stored word on b_rdata after RD_LAT cycles, with b_rvalid=1 for one cycle.
REQ-028 Port B reading the address port A writes in the same cycle SHALL return the old word.
REQ-029 Disabled port (en=0) SHALL drive rdata=0 and rvalid=0 RD_LAT cycles later.
REQ-030 Address >= DEPTH on an enabled port SHALL suppress the write, return rdata=0 with rvalid=1, and set err_oor on the following cycle.
REQ-031 err_oor SHALL clear on err_clr=1; a new out-of-range access in the same cycle as err_clr SHALL win (err_oor stays 1).
REQ-032 RD_LAT=2 SHALL add one output register stage to both ports; pipelines accept a new access every cycle (full throughput).
REQ-033 Both ports enabled every cycle SHALL produce no stall and no lost access.

Reset
REQ-034 rst_n=0 SHALL asynchronously force a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0, init_done=0, err_oor=0, sweep counter=0, state INIT.
REQ-035 Reset asserted mid-INIT or mid-READY SHALL discard in-flight reads and restart the full clear sweep on release.

Verification
REQ-036 Release reset, DEPTH=208 -> init_done rises exactly 208 cycles later; read of addr 207 returns 0x00000000.
REQ-037 Write A addr 5 data 0xAABBCCDD be=1111, then write addr 5 data 0x11223344 be=0101 -> second access returns 0xAABBCCDD; later read returns 0xAA22CC44.
REQ-038 Same cycle: A writes addr 9 data 0xFFFFFFFF, B reads addr 9 (was 0x0) -> b_rdata=0x00000000; next B read -> 0xFFFFFFFF.
REQ-039 A write addr 300 -> a_rdata=0, err_oor=1 next cycle, no memory word changed; err_clr=1 with concurrent B read addr 250 -> err_oor remains 1.
REQ-040 RD_LAT=2, back-to-back B reads addr 0..3 preloaded 1..4 -> b_rdata 1,2,3,4 on consecutive cycles starting 2 cycles after first request.
REQ-041 Assert rst_n=0 at sweep count 100 -> outputs zero immediately; init_done rises 208 cycles after release.
